// File: rtl/fb_stream_src.sv
// rtl/fb_stream_src.sv - frame buffer burst read master feeding a ready/valid pixel stream
//
// Fetches pWORDS words per frame, starting at a base word address latched at
// frame start, using burst reads of up to pBURST words. Returned words go into a
// pFIFO_DEPTH-entry FIFO. A new burst is only requested when the FIFO plus all
// words still in flight leave room for a full burst, so the FIFO never overflows
// even if the sink stalls for a whole vertical blank.
//
// Ports:
//   iCLK               clock, all logic on the rising edge
//   iRESETn            asynchronous active-low reset
//   iENABLE            fetch frames while high; a started frame always completes
//   iBASE              frame base word address, sampled when a frame starts
//   oAV_ADDRESS        read command word address
//   oAV_READ           read command valid, held until accepted
//   oAV_BURSTCOUNT     read command burst length
//   iAV_WAITREQUEST    slave stall, command accepted when low
//   iAV_READDATA       read data (bits 30:0 carry the pixel word)
//   iAV_READDATAVALID  read data qualifier
//   oFB_START          head word is the first word of a frame
//   oFB_DATA           head pixel word
//   oFB_DATAVALID      FIFO not empty
//   iFB_READY          sink takes the head word when high with oFB_DATAVALID
//   oFRAME_DONE        one-cycle pulse after the last word of a frame is taken

module fb_stream_src #(
  parameter int pWORDS      = 921600,
  parameter int pBURST      = 8,
  parameter int pFIFO_DEPTH = 16,
  parameter int pADDR_W     = 22
) (
  input  logic                    iCLK,
  input  logic                    iRESETn,
  input  logic                    iENABLE,
  input  logic [pADDR_W-1:0]      iBASE,
  output logic [pADDR_W-1:0]      oAV_ADDRESS,
  output logic                    oAV_READ,
  output logic [$clog2(pBURST):0] oAV_BURSTCOUNT,
  input  logic                    iAV_WAITREQUEST,
  input  logic [31:0]             iAV_READDATA,
  input  logic                    iAV_READDATAVALID,
  output logic                    oFB_START,
  output logic [30:0]             oFB_DATA,
  output logic                    oFB_DATAVALID,
  input  logic                    iFB_READY,
  output logic                    oFRAME_DONE
);

  localparam int BC_W  = $clog2(pBURST) + 1;
  localparam int REM_W = $clog2(pWORDS + 1);
  localparam int PTR_W = $clog2(pFIFO_DEPTH);
  localparam int CNT_W = $clog2(pFIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, CRED, DRAIN} state_t;

  // Length of the next burst: a full burst, or whatever is left of the frame.
  function automatic logic [BC_W-1:0] burst_len(input logic [REM_W-1:0] rem);
    if (32'(rem) >= 32'(pBURST)) return BC_W'(pBURST);
    return BC_W'(rem);
  endfunction

  state_t             state;
  logic [REM_W-1:0]   remaining;
  logic [REM_W-1:0]   rem_after;
  logic [CNT_W-1:0]   outstanding;
  logic               first_tag;

  logic [31:0]        mem [pFIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic [31:0]        head;

  logic [REM_W-1:0]   out_cnt;

  logic               cmd_accept;
  logic               push;
  logic               pop;
  logic [31:0]        credit_need;
  logic               credit_ok;
  logic               unused_rdata_msb;

  assign unused_rdata_msb = iAV_READDATA[31];

  assign cmd_accept = oAV_READ && !iAV_WAITREQUEST;
  // Data is only taken while we are owed words; this discards anything the
  // slave still returns for bursts issued before a reset.
  assign push       = iAV_READDATAVALID && (outstanding != '0);
  assign fifo_empty = (fifo_count == '0);
  assign pop        = !fifo_empty && iFB_READY;
  assign rem_after  = remaining - REM_W'(oAV_BURSTCOUNT);

  // Words already buffered plus words still in flight must leave room for a
  // full burst. Pushes only move words from "in flight" to "buffered", so the
  // sum can only shrink between this check and the command being accepted.
  assign credit_need = 32'(fifo_count) + 32'(outstanding) + 32'(pBURST);
  assign credit_ok   = (credit_need <= 32'(pFIFO_DEPTH));

  // Fetch FSM with registered command outputs.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state          <= IDLE;
      remaining      <= '0;
      oAV_ADDRESS    <= '0;
      oAV_READ       <= 1'b0;
      oAV_BURSTCOUNT <= '0;
      first_tag      <= 1'b0;
    end else begin
      if (push) first_tag <= 1'b0;
      case (state)
        IDLE: begin
          // The first burst of a frame also needs credit: the previous frame
          // may still be sitting in the FIFO behind a stalled sink.
          if (iENABLE && credit_ok) begin
            state          <= REQ;
            oAV_ADDRESS    <= iBASE;
            remaining      <= REM_W'(pWORDS);
            oAV_BURSTCOUNT <= burst_len(REM_W'(pWORDS));
            oAV_READ       <= 1'b1;
            first_tag      <= 1'b1;
          end
        end
        REQ: begin
          if (!iAV_WAITREQUEST) begin
            oAV_READ       <= 1'b0;
            oAV_ADDRESS    <= oAV_ADDRESS + pADDR_W'(oAV_BURSTCOUNT);
            remaining      <= rem_after;
            oAV_BURSTCOUNT <= burst_len(rem_after);
            state          <= (rem_after == '0) ? DRAIN : CRED;
          end
        end
        CRED: begin
          if (credit_ok) begin
            oAV_READ <= 1'b1;
            state    <= REQ;
          end
        end
        DRAIN: begin
          if (outstanding == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Words requested but not yet returned.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      outstanding <= '0;
    end else begin
      case ({cmd_accept, push})
        2'b10:   outstanding <= outstanding + CNT_W'(oAV_BURSTCOUNT);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        2'b11:   outstanding <= outstanding + CNT_W'(oAV_BURSTCOUNT) - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // FIFO storage holds {first-of-frame flag, pixel word}; no reset needed since
  // the outputs are masked while empty.
  always_ff @(posedge iCLK) begin
    if (push) mem[wr_ptr] <= {first_tag, iAV_READDATA[30:0]};
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign head          = mem[rd_ptr];
  assign oFB_DATAVALID = !fifo_empty;
  assign oFB_DATA      = fifo_empty ? 31'd0 : head[30:0];
  assign oFB_START     = fifo_empty ? 1'b0 : head[31];

  // Output word counter; the pulse lands in the cycle after the last transfer.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      out_cnt     <= '0;
      oFRAME_DONE <= 1'b0;
    end else begin
      oFRAME_DONE <= 1'b0;
      if (pop) begin
        if (out_cnt == REM_W'(pWORDS - 1)) begin
          out_cnt     <= '0;
          oFRAME_DONE <= 1'b1;
        end else begin
          out_cnt <= out_cnt + REM_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_stream_src.sv
// tb/tb_fb_stream_src.sv - randomized model-checked bench for fb_stream_src
module tb_fb_stream_src;

  localparam int WORDS = 20;
  localparam int BURST = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 22;

  logic          iCLK = 1'b0;
  logic          iRESETn = 1'b0;
  logic          iENABLE = 1'b0;
  logic [AW-1:0] iBASE = '0;
  logic          iAV_WAITREQUEST = 1'b0;
  logic [31:0]   iAV_READDATA = '0;
  logic          iAV_READDATAVALID = 1'b0;
  logic          iFB_READY = 1'b0;

  logic [AW-1:0] oAV_ADDRESS;
  logic          oAV_READ;
  logic [3:0]    oAV_BURSTCOUNT;
  logic          oFB_START;
  logic [30:0]   oFB_DATA;
  logic          oFB_DATAVALID;
  logic          oFRAME_DONE;

  fb_stream_src #(
    .pWORDS(WORDS), .pBURST(BURST), .pFIFO_DEPTH(DEPTH), .pADDR_W(AW)
  ) dut (
    .iCLK(iCLK), .iRESETn(iRESETn), .iENABLE(iENABLE), .iBASE(iBASE),
    .oAV_ADDRESS(oAV_ADDRESS), .oAV_READ(oAV_READ), .oAV_BURSTCOUNT(oAV_BURSTCOUNT),
    .iAV_WAITREQUEST(iAV_WAITREQUEST), .iAV_READDATA(iAV_READDATA),
    .iAV_READDATAVALID(iAV_READDATAVALID),
    .oFB_START(oFB_START), .oFB_DATA(oFB_DATA), .oFB_DATAVALID(oFB_DATAVALID),
    .iFB_READY(iFB_READY), .oFRAME_DONE(oFRAME_DONE)
  );

  always #5 iCLK = ~iCLK;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [AW-1:0] pending[$];      // words requested, not yet returned
  logic [31:0]   exp_q[$];        // {start, data} words not yet delivered
  int            occ = 0;         // words buffered in the DUT
  int            in_frame_cmd = 0;
  logic [AW-1:0] frame_base = '0;
  int            frame_words = 0;
  int            frames_done = 0;
  int            cmds_total = 0;
  bit            done_exp = 1'b0;

  bit            prev_stall_cmd = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [3:0]    prev_bc = '0;
  bit            prev_stall_out = 1'b0;
  logic [30:0]   prev_data = '0;
  bit            prev_start = 1'b0;

  // Stimulus modes
  int wait_mode  = 0;   // 0 never, 1 random, 2 always
  int ready_mode = 1;   // 0 never, 1 always, 2 random
  int rdv_mode   = 1;   // 1 return as soon as possible, 2 random gaps
  bit base_jitter  = 1'b0;
  bit expect_idle  = 1'b0;
  bit stale_inject = 1'b0;

  logic [AW-1:0] cmd_addr_log[$];
  logic [3:0]    cmd_bc_log[$];
  logic [31:0]   xfer_log[$];

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return 32'h8000_0000 | ((32'(a) * 32'd3) + 32'd5);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    bit          acc, rdv, xfer, done_next;
    int          bc_exp, pend_pre, sum;
    logic [31:0] w;
    logic [AW-1:0] a;
    @(negedge iCLK);
    // Output checks against the model
    chk("fifo_valid", 64'(oFB_DATAVALID), 64'(occ > 0));
    if (occ > 0 && exp_q.size() > 0) begin
      w = exp_q[0];
      chk("head_data", 64'(oFB_DATA), 64'(w[30:0]));
      chk("head_start", 64'(oFB_START), 64'(w[31]));
    end else if (occ == 0) begin
      chk("empty_outputs", 64'({oFB_START, oFB_DATA}), 64'(0));
    end
    chk("frame_done", 64'(oFRAME_DONE), 64'(done_exp));
    if (prev_stall_cmd) begin
      chk("stall_read", 64'(oAV_READ), 64'(1));
      chk("stall_addr", 64'(oAV_ADDRESS), 64'(prev_addr));
      chk("stall_burst", 64'(oAV_BURSTCOUNT), 64'(prev_bc));
    end
    if (prev_stall_out) begin
      chk("hold_valid", 64'(oFB_DATAVALID), 64'(1));
      chk("hold_data", 64'(oFB_DATA), 64'(prev_data));
      chk("hold_start", 64'(oFB_START), 64'(prev_start));
    end
    if (expect_idle) chk("idle_read", 64'(oAV_READ), 64'(0));

    // Drive inputs for the coming rising edge
    iAV_WAITREQUEST = (wait_mode == 2) ? 1'b1 :
                      (wait_mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
    iFB_READY = (ready_mode == 0) ? 1'b0 :
                (ready_mode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
    if (base_jitter && in_frame_cmd != 0 && $urandom_range(0, 7) == 0)
      iBASE = AW'($urandom_range(0, 32'h3FFFF));
    pend_pre = pending.size();
    rdv = (pend_pre > 0) && (rdv_mode == 1 || $urandom_range(0, 2) != 0);
    if (rdv) begin
      iAV_READDATAVALID = 1'b1;
      iAV_READDATA = mem_word(pending.pop_front());
    end else begin
      iAV_READDATAVALID = stale_inject;
      iAV_READDATA = $urandom;
    end

    // Events at the coming edge
    acc  = oAV_READ && !iAV_WAITREQUEST;
    xfer = oFB_DATAVALID && iFB_READY;
    done_next = 1'b0;
    if (acc) begin
      if (in_frame_cmd == 0) begin
        frame_base = iBASE;
        for (int i = 0; i < WORDS; i++) begin
          w = mem_word(frame_base + AW'(i));
          exp_q.push_back({(i == 0) ? 1'b1 : 1'b0, w[30:0]});
        end
      end
      bc_exp = (WORDS - in_frame_cmd < BURST) ? WORDS - in_frame_cmd : BURST;
      a = frame_base + AW'(in_frame_cmd);
      chk("cmd_addr", 64'(oAV_ADDRESS), 64'(a));
      chk("cmd_burst", 64'(oAV_BURSTCOUNT), 64'(bc_exp));
      sum = occ + pend_pre + bc_exp;
      chk("credit_room", 64'(sum <= DEPTH), 64'(1));
      for (int k = 0; k < bc_exp; k++) pending.push_back(a + AW'(k));
      cmd_addr_log.push_back(oAV_ADDRESS);
      cmd_bc_log.push_back(oAV_BURSTCOUNT);
      cmds_total++;
      in_frame_cmd += bc_exp;
      if (in_frame_cmd >= WORDS) in_frame_cmd = 0;
    end
    if (xfer) begin
      xfer_log.push_back({oFB_START, oFB_DATA});
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      frame_words++;
      if (frame_words == WORDS) begin
        frame_words = 0;
        frames_done++;
        done_next = 1'b1;
      end
    end
    occ = occ + (rdv ? 1 : 0) - (xfer ? 1 : 0);
    done_exp = done_next;
    prev_stall_cmd = oAV_READ && iAV_WAITREQUEST;
    prev_addr = oAV_ADDRESS;
    prev_bc = oAV_BURSTCOUNT;
    prev_stall_out = oFB_DATAVALID && !iFB_READY;
    prev_data = oFB_DATA;
    prev_start = oFB_START;
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge iCLK);
    iRESETn = 1'b0;
    #1;
    chk("rst_read", 64'(oAV_READ), 64'(0));
    chk("rst_addr", 64'(oAV_ADDRESS), 64'(0));
    chk("rst_burst", 64'(oAV_BURSTCOUNT), 64'(0));
    chk("rst_start", 64'(oFB_START), 64'(0));
    chk("rst_data", 64'(oFB_DATA), 64'(0));
    chk("rst_valid", 64'(oFB_DATAVALID), 64'(0));
    chk("rst_done", 64'(oFRAME_DONE), 64'(0));
    pending.delete();
    exp_q.delete();
    occ = 0;
    in_frame_cmd = 0;
    frame_words = 0;
    done_exp = 1'b0;
    prev_stall_cmd = 1'b0;
    prev_stall_out = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge iCLK);
      iAV_READDATAVALID = 1'($urandom_range(0, 1));
      iAV_READDATA = $urandom;
      chk("rst_hold_read", 64'(oAV_READ), 64'(0));
      chk("rst_hold_valid", 64'(oFB_DATAVALID), 64'(0));
    end
    @(negedge iCLK);
    iRESETn = 1'b1;
    iAV_READDATAVALID = 1'b0;
  endtask

  task automatic run_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_done < target && n < budget) begin
      step();
      n++;
    end
    chk("frame_timeout", 64'(frames_done >= target), 64'(1));
  endtask

  initial begin
    int n, c0, cnt;
    logic [31:0] w;

    // Reset, then a plain frame at 0x100 with enable dropped after word 3
    iBASE = 22'h100;
    apply_reset(3);
    iENABLE = 1'b1;
    n = 0;
    while (xfer_log.size() < 4 && n < 200) begin step(); n++; end
    chk("word3_timeout", 64'(xfer_log.size() >= 4), 64'(1));
    iENABLE = 1'b0;
    run_frames(1, 300);
    expect_idle = 1'b1;
    repeat (30) step();
    expect_idle = 1'b0;
    chk("f0_cmds", 64'(cmds_total), 64'(3));
    if (cmd_addr_log.size() >= 3) begin
      chk("f0_addr0", 64'(cmd_addr_log[0]), 64'(22'h100));
      chk("f0_addr1", 64'(cmd_addr_log[1]), 64'(22'h108));
      chk("f0_addr2", 64'(cmd_addr_log[2]), 64'(22'h110));
      chk("f0_bc0", 64'(cmd_bc_log[0]), 64'(8));
      chk("f0_bc1", 64'(cmd_bc_log[1]), 64'(8));
      chk("f0_bc2", 64'(cmd_bc_log[2]), 64'(4));
    end
    chk("f0_words", 64'(xfer_log.size()), 64'(20));
    if (xfer_log.size() >= 20) begin
      chk("f0_first", 64'(xfer_log[0]), 64'({1'b1, 31'h305}));
      chk("f0_last", 64'(xfer_log[19]), 64'({1'b0, 31'h33E}));
    end

    // Sink stalled for 100 cycles: only two bursts fit the credit
    iBASE = 22'h200;
    ready_mode = 0;
    c0 = cmds_total;
    iENABLE = 1'b1;
    repeat (100) step();
    chk("stall_cmds", 64'(cmds_total - c0), 64'(2));
    chk("stall_valid", 64'(oFB_DATAVALID), 64'(1));
    chk("stall_head", 64'(oFB_DATA), 64'(31'h605));
    chk("stall_sof", 64'(oFB_START), 64'(1));
    ready_mode = 2;
    run_frames(2, 1000);

    // Slave stalls a command for 5 cycles
    wait_mode = 2;
    n = 0;
    while (!oAV_READ && n < 100) begin step(); n++; end
    chk("req_timeout", 64'(oAV_READ), 64'(1));
    c0 = cmds_total;
    cnt = 0;
    repeat (5) begin
      step();
      if (oAV_READ) cnt++;
    end
    wait_mode = 0;
    step();
    chk("waitreq_cycles", 64'(cnt), 64'(5));
    chk("waitreq_one_cmd", 64'(cmds_total - c0), 64'(1));

    // Random traffic with mid-frame base changes
    wait_mode = 1;
    rdv_mode = 2;
    ready_mode = 2;
    base_jitter = 1'b1;
    run_frames(frames_done + 4, 6000);
    base_jitter = 1'b0;

    // Reset during the second burst of a frame
    wait_mode = 0;
    n = 0;
    while (!(in_frame_cmd == 16 && pending.size() > 0) && n < 500) begin step(); n++; end
    chk("burst2_timeout", 64'(in_frame_cmd), 64'(16));
    iBASE = 22'h300;
    apply_reset(2);
    wait_mode = 2;
    stale_inject = 1'b1;
    step();
    stale_inject = 1'b0;
    step();
    step();
    wait_mode = 0;
    ready_mode = 1;
    rdv_mode = 1;
    xfer_log.delete();
    run_frames(frames_done + 1, 400);
    if (xfer_log.size() > 0) begin
      w = xfer_log[0];
      chk("post_rst_first", 64'(w), 64'({1'b1, 31'h905}));
    end else begin
      chk("post_rst_words", 64'(xfer_log.size()), 64'(20));
    end

    iENABLE = 1'b0;
    repeat (5) @(negedge iCLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
